// File: rtl/flexbex_hpm_counter_unit_if.sv
// rtl/flexbex_hpm_counter_unit_if.sv - CSR bus shared between the CS register block and the HPM unit
//
// Signals:
//   csr_access  CSR access valid this cycle
//   csr_addr    12-bit CSR address
//   csr_wdata   32-bit write operand
//   csr_op      0=read, 1=write, 2=set, 3=clear
//   csr_rdata   read data returned by the unit (combinational)
//   csr_hit     address decoded by the unit
// Modports: master (CS register block / bench), slave (HPM unit).
interface flexbex_hpm_counter_unit_if;
    logic        csr_access;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [1:0]  csr_op;
    logic [31:0] csr_rdata;
    logic        csr_hit;

    modport master (
        output csr_access, csr_addr, csr_wdata, csr_op,
        input  csr_rdata, csr_hit
    );

    modport slave (
        input  csr_access, csr_addr, csr_wdata, csr_op,
        output csr_rdata, csr_hit
    );
endinterface

// File: rtl/flexbex_hpm_counter_unit.sv
// rtl/flexbex_hpm_counter_unit.sv - parametrised hardware performance-monitor counters with mhpm CSR access
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   csr       CSR bus (slave modport): access/addr/wdata/op in, rdata/hit out
//   event_i   N_EVT single-cycle event pulses
//   irq_o     registered overflow interrupt (0 unless FLEXBEX_HPM_OVF_IRQ_EN)
// Optional feature macro: FLEXBEX_HPM_OVF_IRQ_EN (sticky overflow bits at 0x7C0,
// per-counter interrupt enable at mhpmevent bit 30).
module flexbex_hpm_counter_unit #(
    parameter int N_CNT = 4,
    parameter int CNT_W = 48,
    parameter int N_EVT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    flexbex_hpm_counter_unit_if.slave csr,
    input  logic [N_EVT-1:0]          event_i,
    output logic                      irq_o
);
    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q [N_CNT];
    logic [CNT_W-1:0] cnt_d [N_CNT];
    logic [4:0]       sel_q [N_CNT];
    logic [4:0]       sel_d [N_CNT];
    logic [N_CNT-1:0] sat_q, sat_d;
    logic [N_CNT-1:0] inh_q, inh_d;
    logic [N_CNT-1:0] evt_q, evt_d;
    logic [N_CNT-1:0] ien;
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
    logic [N_CNT-1:0] ien_q, ien_d;
    logic [N_CNT-1:0] ovf_q, ovf_d, ovf_set;
    logic             irq_q;
`endif

    logic        wr_en;
    logic [31:0] set_m;   // bits forced to 1 by the op
    logic [31:0] keep_m;  // bits of the old field kept by the op
    logic [31:0] inh_word;
    logic [31:0] evt_word [N_CNT];

    assign wr_en = csr.csr_access && (csr.csr_op != 2'd0);

    // Every op is expressed as F' = (F & keep_m) | set_m, so each field
    // (of any width) is updated with the same two masks.
    always_comb begin
        set_m  = '0;
        keep_m = '1;
        case (csr.csr_op)
            2'd1:    begin set_m = csr.csr_wdata; keep_m = '0;              end
            2'd2:    begin set_m = csr.csr_wdata; keep_m = '1;              end
            2'd3:    begin set_m = '0;            keep_m = ~csr.csr_wdata;  end
            default: begin set_m = '0;            keep_m = '1;              end
        endcase
    end

`ifdef FLEXBEX_HPM_OVF_IRQ_EN
    assign ien = ien_q;
`else
    assign ien = '0;
`endif

    // Read view and decode
    always_comb begin
        inh_word      = '0;
        csr.csr_rdata = '0;
        csr.csr_hit   = 1'b0;
        for (int i = 0; i < N_CNT; i++) begin
            inh_word[i+3] = inh_q[i];
            evt_word[i]   = {sat_q[i], ien[i], 25'd0, sel_q[i]};
        end
        if (csr.csr_access) begin
            if (csr.csr_addr == 12'h320) begin
                csr.csr_hit   = 1'b1;
                csr.csr_rdata = inh_word;
            end
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
            if (csr.csr_addr == 12'h7C0) begin
                csr.csr_hit   = 1'b1;
                csr.csr_rdata = 32'(ovf_q);
            end
`endif
            for (int i = 0; i < N_CNT; i++) begin
                if (csr.csr_addr == 12'h323 + 12'(i)) begin
                    csr.csr_hit   = 1'b1;
                    csr.csr_rdata = evt_word[i];
                end
                if (csr.csr_addr == 12'hB03 + 12'(i)) begin
                    csr.csr_hit   = 1'b1;
                    csr.csr_rdata = cnt_q[i][31:0];
                end
                if (csr.csr_addr == 12'hB83 + 12'(i)) begin
                    csr.csr_hit   = 1'b1;
                    csr.csr_rdata = 32'(cnt_q[i][CNT_W-1:32]);
                end
            end
        end
    end

    // Next state
    always_comb begin
        logic lo_w, hi_w, ev;
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
        ovf_set = '0;
`endif
        for (int i = 0; i < N_CNT; i++) begin
            sel_d[i] = sel_q[i];
            sat_d[i] = sat_q[i];
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
            ien_d[i] = ien_q[i];
`endif
            if (wr_en && csr.csr_addr == 12'h323 + 12'(i)) begin
                sel_d[i] = (sel_q[i] & keep_m[4:0]) | set_m[4:0];
                sat_d[i] = (sat_q[i] & keep_m[31]) | set_m[31];
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
                ien_d[i] = (ien_q[i] & keep_m[30]) | set_m[30];
`endif
            end

            inh_d[i] = inh_q[i];
            if (wr_en && csr.csr_addr == 12'h320)
                inh_d[i] = (inh_q[i] & keep_m[i+3]) | set_m[i+3];

            // sel is 1-based; 0 and values above N_EVT match nothing
            ev = 1'b0;
            for (int e = 0; e < N_EVT; e++)
                if (sel_q[i] == 5'(e + 1)) ev = event_i[e];
            evt_d[i] = ev & ~inh_q[i];

            // A CSR write to either half wins over a pending increment
            lo_w     = wr_en && (csr.csr_addr == 12'hB03 + 12'(i));
            hi_w     = wr_en && (csr.csr_addr == 12'hB83 + 12'(i));
            cnt_d[i] = cnt_q[i];
            if (lo_w)
                cnt_d[i][31:0] = (cnt_q[i][31:0] & keep_m) | set_m;
            if (hi_w)
                cnt_d[i][CNT_W-1:32] = (cnt_q[i][CNT_W-1:32] & keep_m[HI_W-1:0]) | set_m[HI_W-1:0];
            if (!lo_w && !hi_w && evt_q[i]) begin
                if (&cnt_q[i]) begin
                    if (!sat_q[i]) begin
                        cnt_d[i] = '0;
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
                        ovf_set[i] = 1'b1;
`endif
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
        ovf_d = ovf_q;
        if (wr_en && csr.csr_addr == 12'h7C0)
            ovf_d = ovf_d & ~csr.csr_wdata[N_CNT-1:0];
        ovf_d = ovf_d | ovf_set;  // a wrap in the clearing cycle keeps the bit set
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= '0;
                sel_q[i] <= '0;
            end
            sat_q <= '0;
            inh_q <= '0;
            evt_q <= '0;
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
            ien_q <= '0;
            ovf_q <= '0;
            irq_q <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < N_CNT; i++) begin
                cnt_q[i] <= cnt_d[i];
                sel_q[i] <= sel_d[i];
            end
            sat_q <= sat_d;
            inh_q <= inh_d;
            evt_q <= evt_d;
`ifdef FLEXBEX_HPM_OVF_IRQ_EN
            ien_q <= ien_d;
            ovf_q <= ovf_d;
            irq_q <= |(ovf_q & ien_q);
`endif
        end
    end

`ifdef FLEXBEX_HPM_OVF_IRQ_EN
    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif
endmodule

// File: doc/flexbex_hpm_counter_unit.md
Name: flexbex_hpm_counter_unit

Overview:
- Parametrised hardware performance-monitor unit for the flexbex core.
- Replaces the fixed 11-entry, 32-bit PCCR/PCER/PCMR scheme with N_CNT programmable counters of CNT_W bits.
- Each counter has its own event selector, a wrap/saturate mode bit, and inhibit control, all reached through RISC-V-style mhpm CSR addresses.
- Sits beside the CS register block and shares its csr_access/csr_addr/csr_op bus; that block muxes csr_rdata_o in when csr_hit_o is high.

Parameters:
- N_CNT, 4, number of programmable counters (1..29).
- CNT_W, 48, counter width in bits (33..64).
- N_EVT, 16, number of event inputs (1..31).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- csr_access_i  input  1  CSR access valid this cycle
- csr_addr_i  input  12  CSR address
- csr_wdata_i  input  32  CSR write operand
- csr_op_i  input  2  0=read, 1=write, 2=set, 3=clear
- csr_rdata_o  output  32  read data (combinational)
- csr_hit_o  output  1  address decoded by this unit
- event_i  input  N_EVT  single-cycle event pulses from the pipeline
- irq_o  output  1  overflow interrupt (present only with the macro)

Behaviour:
- Address map, i = 0..N_CNT-1:
  - 0x320: mcountinhibit. Bit i+3 inhibits counter i; other bits read 0.
  - 0x323+i: mhpmevent_i. Bits [4:0] = sel; bit 31 = sat. Other bits read 0.
  - 0xB03+i: counter i bits [31:0].
  - 0xB83+i: counter i bits [CNT_W-1:32], zero-extended to 32.
- Unmapped address or csr_access_i=0: csr_hit_o=0 and csr_rdata_o=0.
- Op semantics on the addressed field F:
  - write: F = wdata.
  - set: F = F | wdata.
  - clear: F = F & ~wdata.
  - read: no change.
  - Updates take effect at the next clk edge.
- Event pipeline:
  - At each edge, evt_q[i] <= (sel_i in 1..N_EVT) & event_i[sel_i-1] & ~inhibit_i.
  - sel = 0 or sel > N_EVT never counts.
  - At the following edge, counter i += evt_q[i]. Latency from event pulse to visible count: 2 cycles.
- Wrap mode (sat=0): all-ones + 1 -> 0. Sets ovf_i when the macro is defined.
- Saturate mode (sat=1): all-ones + 1 stays all-ones. No ovf.
- CSR write collision: a CSR write/set/clear to either half of counter i in the same cycle as an increment takes priority; that increment is dropped.
  - Lo access modifies only bits [31:0]; hi access modifies only bits [CNT_W-1:32].
- Changing sel or inhibit affects evt_q from the next edge on; an evt_q already captured still counts.
- Reset values:
  - All counters 0; evt_q 0.
  - All mhpmevent 0 (disabled).
  - mcountinhibit 0; ovf 0; irq_o 0.
- Reset mid-operation clears everything asynchronously; in-flight evt_q is lost.

Optional Feature:
- Macro: FLEXBEX_HPM_OVF_IRQ_EN.
- Defined:
  - Each counter gets a sticky ovf_i bit and a per-counter enable at mhpmevent_i bit 30.
  - CSR 0x7C0 reads the ovf bits at [N_CNT-1:0]; writing 1 to a bit clears it (any op except read).
  - irq_o is registered: irq_o <= |(ovf & irq_en).
  - If a wrap and a clear of the same ovf bit occur in one cycle, the wrap wins and the bit stays 1.
- Undefined:
  - No ovf logic.
  - 0x7C0 unmapped and bit 30 reads 0.
  - irq_o tied to 0.

Test Plan:
- Reset, then read 0x320, 0x323, 0xB03 and 0xB83 -> all 0, csr_hit_o=1. Read 0x7FF -> csr_hit_o=0, data 0.
- Write 0x323=0x3 (sel 3), pulse event_i[2] at cycle t -> 0xB03 reads 0 at t+1 and 1 at t+2. Ten back-to-back pulses -> 10.
- Write 0xB03=0xFFFFFFFF and 0xB83=0xFFFF (CNT_W=48), sat=0, one event -> lo=0, hi=0. With macro and 0x323 bit30=1, 0x7C0=0x1 and irq_o=1 one cycle later.
- Same setup with 0x323 bit31=1 (saturate) -> stays lo 0xFFFFFFFF / hi 0xFFFF, ovf=0.
- Counter at 5, event captured in evt_q while op=write 0x64 to 0xB03 in the same cycle -> reads 0x64, not 0x65.
- Set 0x320 bit3 via op=2, pulse the selected event -> no increment. Clear bit3 via op=3 with wdata 0x8 -> counting resumes with 2-cycle latency.
